// File: rtl/wavetable.sv
// Wavetable oscillator read engine: divides clk by a programmable sample period,
// fetches one wavetable word per period over an address/strobe RAM port, and
// advances a 10-bit {rbank, RADDR} phase accumulator by 2^step_input per fetch.
// Optional feature macro: SUB_OSC_EN builds the sub-octave square output;
// without it SUB_OUT is tied low.
// Widths come from the global defines DATAWIDTH (default 16) and ADDRWIDTH (default 8).
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | waiting for a period tick
// S_WAIT   | one cycle with RADDR stable ahead of the strobe
// S_STROBE | final cycle before RCLK goes high (RCLK registered off this state)
// S_LATCH  | RCLK high; at its closing edge dout captures RDATA and the phase advances

`ifndef DATAWIDTH
`define DATAWIDTH 16
`endif
`ifndef ADDRWIDTH
`define ADDRWIDTH 8
`endif

module wavetable (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [`DATAWIDTH-1:0] Fs_input,
    input  logic [2:0]            step_input,
    input  logic                  enable,
    input  logic [`DATAWIDTH-1:0] RDATA,
    output logic [`ADDRWIDTH-1:0] RADDR,
    output logic [1:0]            rbank,
    output logic                  RCLK,
    output logic [`DATAWIDTH-1:0] dout,
    output logic                  SUB_OUT
);

    localparam int DW = `DATAWIDTH;
    localparam int AW = `ADDRWIDTH;
    localparam int PW = AW + 2;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WAIT   = 2'd1,
        S_STROBE = 2'd2,
        S_LATCH  = 2'd3
    } state_t;

    state_t         state;
    state_t         state_nx;
    logic [DW-1:0]  cnt;
    logic           tick;
    logic           strobe_nx;
    logic           latch;
    logic [PW-1:0]  inc;
    logic [PW-1:0]  phase_nx;

    // Fs_input is compared live so a new period applies at the next compare.
    assign tick = enable && (cnt == Fs_input);

    // Shifts past the top of the accumulator simply fall off.
    assign inc      = PW'(1) << step_input;
    assign phase_nx = {rbank, RADDR} + inc;

    // Period counter: held at zero while disabled, wraps on tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (!enable || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + DW'(1);
        end
    end

    // Sequencer state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state decode; ticks outside IDLE are dropped, giving a 4-clock minimum period.
    always_comb begin
        state_nx  = state;
        strobe_nx = 1'b0;
        latch     = 1'b0;
        case (state)
            S_IDLE:   if (tick) state_nx = S_WAIT;
            S_WAIT:   state_nx = S_STROBE;
            S_STROBE: begin
                state_nx  = S_LATCH;
                strobe_nx = 1'b1;
            end
            S_LATCH:  begin
                state_nx = S_IDLE;
                latch    = 1'b1;
            end
            default:  state_nx = S_IDLE;
        endcase
    end

    // RAM strobe: high for exactly the LATCH cycle, dropped asynchronously by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            RCLK <= 1'b0;
        end else begin
            RCLK <= strobe_nx;
        end
    end

    // Capture the fetched word and advance the phase on the LATCH edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout  <= '0;
            RADDR <= '0;
            rbank <= '0;
        end else if (latch) begin
            dout           <= RDATA;
            {rbank, RADDR} <= phase_nx;
        end
    end

`ifdef SUB_OSC_EN
    logic [AW:0] addr_sum;

    // Carry out of the address field alone, independent of bank bits in the increment.
    assign addr_sum = {1'b0, RADDR} + {1'b0, inc[AW-1:0]};

    // Sub-octave square: toggles each time RADDR wraps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            SUB_OUT <= 1'b0;
        end else if (latch && addr_sum[AW]) begin
            SUB_OUT <= ~SUB_OUT;
        end
    end
`else
    assign SUB_OUT = 1'b0;
`endif

endmodule

// File: tb/tb_wavetable.sv
// Scoreboard bench for wavetable: stimulus pushes the expected result of each
// fetch (data, phase, sub output, latch cycle); a monitor pops on every RCLK
// pulse and compares at the latch edge. Honours SUB_OSC_EN for SUB_OUT.

`ifndef DATAWIDTH
`define DATAWIDTH 16
`endif
`ifndef ADDRWIDTH
`define ADDRWIDTH 8
`endif

module tb_wavetable;

    localparam int DW = `DATAWIDTH;
    localparam int AW = `ADDRWIDTH;
`ifdef SUB_OSC_EN
    localparam bit SUB_EN = 1'b1;
`else
    localparam bit SUB_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          enable = 1'b0;
    logic [DW-1:0] Fs_input = '0;
    logic [2:0]    step_input = '0;
    logic [DW-1:0] RDATA = '0;
    logic [AW-1:0] RADDR;
    logic [1:0]    rbank;
    logic          RCLK;
    logic [DW-1:0] dout;
    logic          SUB_OUT;

    wavetable dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .Fs_input   (Fs_input),
        .step_input (step_input),
        .enable     (enable),
        .RDATA      (RDATA),
        .RADDR      (RADDR),
        .rbank      (rbank),
        .RCLK       (RCLK),
        .dout       (dout),
        .SUB_OUT    (SUB_OUT)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // RAM model: the word presented advances on every strobe rise.
    always @(posedge RCLK) RDATA <= RDATA + 1'b1;

    typedef struct {
        logic [DW-1:0] d;
        logic [AW-1:0] a;
        logic [1:0]    b;
        logic          s;
        int            c;
    } exp_t;

    exp_t          exp_q[$];
    exp_t          cur;
    int            n_vec = 0;
    int            n_bad = 0;
    logic [DW-1:0] exp_data = '0;
    logic          exp_sub = 1'b0;
    int            c0;

    // Phase sequence from 0: descending steps land on 0xFE, then carries into each bank.
    logic [2:0]    step_tab  [14] = '{3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1,
                                      3'd1, 3'd7, 3'd7, 3'd7, 3'd7, 3'd7, 3'd7};
    logic [7:0]    raddr_tab [14] = '{8'h80, 8'hC0, 8'hE0, 8'hF0, 8'hF8, 8'hFC, 8'hFE,
                                      8'h00, 8'h80, 8'h00, 8'h80, 8'h00, 8'h80, 8'h00};
    logic [1:0]    bank_tab  [14] = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0,
                                      2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3, 2'd0};
    logic          carry_tab [14] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                                      1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

    task automatic push(input logic [AW-1:0] a, input logic [1:0] b,
                        input logic carry, input int c);
        exp_t e;
        exp_data = exp_data + 1'b1;
        if (SUB_EN && carry) exp_sub = ~exp_sub;
        e.d = exp_data;
        e.a = a;
        e.b = b;
        e.s = exp_sub;
        e.c = c;
        exp_q.push_back(e);
    endtask

    task automatic check_out(input string name, input logic [DW-1:0] d,
                             input logic [AW-1:0] a, input logic [1:0] b, input logic s);
        n_vec++;
        if (dout !== d || RADDR !== a || rbank !== b || SUB_OUT !== s || RCLK !== 1'b0) begin
            n_bad++;
            $display("FAIL %s: got dout=%0h RADDR=%0h rbank=%0d SUB_OUT=%0b RCLK=%0b, want dout=%0h RADDR=%0h rbank=%0d SUB_OUT=%0b RCLK=0",
                     name, dout, RADDR, rbank, SUB_OUT, RCLK, d, a, b, s);
        end
    endtask

    // Called at a negedge; returns at the first negedge where RCLK is high.
    task automatic wait_strobe(input int limit);
        int k = 0;
        while (RCLK !== 1'b1 && k < limit) begin
            @(negedge clk);
            k++;
        end
        if (RCLK !== 1'b1) begin
            n_vec++;
            n_bad++;
            $display("FAIL strobe_timeout: got no RCLK within %0d cycles, want a strobe", limit);
        end
    endtask

    task automatic wait_drain(input int limit);
        int k = 0;
        while (exp_q.size() != 0 && k < limit) begin
            @(negedge clk);
            k++;
        end
        if (exp_q.size() != 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL drain_timeout: got %0d fetches outstanding, want 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    // Monitor: every RCLK pulse must match the oldest expectation at its latch edge.
    always begin
        @(negedge clk);
        if (rst_n === 1'b1 && RCLK === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL unexpected_strobe: got RCLK=1 at cycle %0d, want no fetch", cyc);
            end else begin
                cur = exp_q.pop_front();
                @(posedge clk);
                #1;
                n_vec++;
                if (dout !== cur.d || RADDR !== cur.a || rbank !== cur.b ||
                    SUB_OUT !== cur.s || cyc !== cur.c) begin
                    n_bad++;
                    $display("FAIL fetch: got dout=%0h RADDR=%0h rbank=%0d SUB_OUT=%0b cycle=%0d, want dout=%0h RADDR=%0h rbank=%0d SUB_OUT=%0b cycle=%0d",
                             dout, RADDR, rbank, SUB_OUT, cyc, cur.d, cur.a, cur.b, cur.s, cur.c);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running, want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset, then idle with enable low (Fs=0 would tick every cycle if not gated).
        repeat (3) @(negedge clk);
        check_out("reset_hold", '0, '0, 2'd0, 1'b0);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check_out("idle_after_reset", '0, '0, 2'd0, 1'b0);

        // Basic fetch: Fs=15, step 0.
        Fs_input   = 16'd15;
        step_input = 3'd0;
        enable     = 1'b1;
        c0         = cyc;
        push(8'h01, 2'd0, 1'b0, c0 + 19);
        push(8'h02, 2'd0, 1'b0, c0 + 35);
        push(8'h03, 2'd0, 1'b0, c0 + 51);
        repeat (17) @(posedge clk);
        #1;
        n_vec++;
        if (RDATA !== '0 || RADDR !== '0 || rbank !== 2'd0) begin
            n_bad++;
            $display("FAIL pre_first_fetch: got RDATA=%0h RADDR=%0h rbank=%0d, want 0 0 0", RDATA, RADDR, rbank);
        end
        wait_drain(80);
        enable = 1'b0;

        // Fresh phase, then step table at the 4-clock minimum period (Fs=0).
        rst_n = 1'b0;
        exp_sub = 1'b0;
        #1;
        check_out("reset_mid_run", '0, '0, 2'd0, 1'b0);
        @(negedge clk);
        rst_n      = 1'b1;
        Fs_input   = '0;
        @(negedge clk);
        c0 = cyc;
        for (int i = 0; i < 14; i++) begin
            step_input = step_tab[i];
            push(raddr_tab[i], bank_tab[i], carry_tab[i], c0 + 4 * (i + 1));
            if (i == 0) enable = 1'b1;
            wait_strobe(12);
            @(negedge clk);
        end
        enable = 1'b0;
        wait_drain(10);

        // Enable dropped one clock after a tick: the sequence in flight completes.
        Fs_input   = 16'd10;
        step_input = 3'd0;
        enable     = 1'b1;
        c0         = cyc;
        push(8'h01, 2'd0, 1'b0, c0 + 14);
        repeat (12) @(negedge clk);
        enable = 1'b0;
        repeat (30) @(negedge clk);
        check_out("hold_after_drop", exp_data, 8'h01, 2'd0, exp_sub);

        // Re-enable: count restarts, phase continues, fetch every 11 clocks.
        step_input = 3'd2;
        enable     = 1'b1;
        c0         = cyc;
        push(8'h05, 2'd0, 1'b0, c0 + 14);
        push(8'h09, 2'd0, 1'b0, c0 + 25);
        push(8'h0D, 2'd0, 1'b0, c0 + 36);
        wait_drain(60);
        enable = 1'b0;
        repeat (20) @(negedge clk);
        check_out("hold_after_reenable", exp_data, 8'h0D, 2'd0, exp_sub);

        // Async reset while RCLK is high.
        Fs_input = '0;
        enable   = 1'b1;
        begin
            int k = 0;
            while (RCLK !== 1'b1 && k < 10) begin
                @(posedge clk);
                #1;
                k++;
            end
        end
        n_vec++;
        if (RCLK !== 1'b1) begin
            n_bad++;
            $display("FAIL async_setup: got RCLK=%0b, want 1 before reset", RCLK);
        end
        rst_n = 1'b0;
        #1;
        check_out("async_reset", '0, '0, 2'd0, 1'b0);
        enable = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check_out("post_async_idle", '0, '0, 2'd0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
